// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: register-file access sequencer.
// Accepts operand-read and write-back requests over a level req / pulse ack
// handshake and drives the register-file pins. A write uses a setup, pulse and
// hold sequence so that address and data are stable around the RegWre pulse.
// Read operands are latched into the A/B operand registers.
// Optional build macro: REGACC_BYPASS_EN.
//   Undefined: a simultaneous read and write is serialized, write first.
//   Defined:   a simultaneous read runs alongside the write, and an operand
//              whose address matches a nonzero write address is forwarded
//              from the captured write data.
module reg_access_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rs_in,
  input  logic [AW-1:0] rt_in,
  output logic          rd_ack,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ack,
  output logic          busy,
  output logic [AW-1:0] rf_rs,
  output logic [AW-1:0] rf_rt,
  input  logic [DW-1:0] rf_do1,
  input  logic [DW-1:0] rf_do2,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_wre
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_ACK   = 3'd2,
    WB_SETUP = 3'd3,
    WB_PULSE = 3'd4,
    WB_HOLD  = 3'd5
  } state_t;

  state_t        state_reg;
  logic          busy_reg;
  logic          rd_ack_reg;
  logic          wb_ack_reg;
  logic          rf_wre_reg;
  logic [AW-1:0] rf_rs_reg;
  logic [AW-1:0] rf_rt_reg;
  logic [AW-1:0] rf_rd_reg;
  logic [DW-1:0] rf_wdata_reg;

`ifdef REGACC_BYPASS_EN
  // High during the address cycle of a read running alongside a write.
  logic          par_rd_reg;
`else
  // Read that arrived together with a write; it runs once the write is done.
  logic          rd_pend_reg;
  logic [AW-1:0] rs_cap_reg;
  logic [AW-1:0] rt_cap_reg;
`endif

  // Operands are loaded at the closing edge of a read address cycle.
  logic          operand_load;
  logic [DW-1:0] rf_do_arr [2];

  assign rf_do_arr[0] = rf_do1;
  assign rf_do_arr[1] = rf_do2;

`ifdef REGACC_BYPASS_EN
  logic [AW-1:0] src_arr [2];

  assign src_arr[0]   = rf_rs_reg;
  assign src_arr[1]   = rf_rt_reg;
  assign operand_load = (state_reg == RD_ADDR) || par_rd_reg;
`else
  assign operand_load = (state_reg == RD_ADDR);
`endif

  // One operand register per read port (A from rf_do1, B from rf_do2).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [DW-1:0] opnd_reg;
      logic [DW-1:0] load_val;

`ifdef REGACC_BYPASS_EN
      // The write has not reached the register file yet when a parallel read
      // samples it, so a matching nonzero address takes the captured data.
      assign load_val = (par_rd_reg && (rf_rd_reg != '0) && (src_arr[gi] == rf_rd_reg))
                        ? rf_wdata_reg : rf_do_arr[gi];
`else
      assign load_val = rf_do_arr[gi];
`endif

      // Latch the operand; it is held until the next read completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opnd_reg <= '0;
        end else if (operand_load) begin
          opnd_reg <= load_val;
        end
      end
    end
  endgenerate

  // Sequencer. This block also registers every handshake and register-file pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      rd_ack_reg   <= 1'b0;
      wb_ack_reg   <= 1'b0;
      rf_wre_reg   <= 1'b0;
      rf_rs_reg    <= '0;
      rf_rt_reg    <= '0;
      rf_rd_reg    <= '0;
      rf_wdata_reg <= '0;
`ifdef REGACC_BYPASS_EN
      par_rd_reg   <= 1'b0;
`else
      rd_pend_reg  <= 1'b0;
      rs_cap_reg   <= '0;
      rt_cap_reg   <= '0;
`endif
    end else begin
      // Acks and the write strobe are single-cycle pulses by default.
      rd_ack_reg <= 1'b0;
      wb_ack_reg <= 1'b0;
      rf_wre_reg <= 1'b0;
`ifdef REGACC_BYPASS_EN
      par_rd_reg <= 1'b0;
      if (par_rd_reg) begin
        rd_ack_reg <= 1'b1;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (wb_req) begin
            // Write has priority. Target and data are captured here and stay
            // on the pins until the next write.
            rf_rd_reg    <= wb_addr;
            rf_wdata_reg <= wb_data;
            state_reg    <= WB_SETUP;
            busy_reg     <= 1'b1;
            if (rd_req) begin
`ifdef REGACC_BYPASS_EN
              rf_rs_reg  <= rs_in;
              rf_rt_reg  <= rt_in;
              par_rd_reg <= 1'b1;
`else
              rs_cap_reg  <= rs_in;
              rt_cap_reg  <= rt_in;
              rd_pend_reg <= 1'b1;
`endif
            end
          end else if (rd_req) begin
            rf_rs_reg <= rs_in;
            rf_rt_reg <= rt_in;
            state_reg <= RD_ADDR;
            busy_reg  <= 1'b1;
          end
        end
        RD_ADDR: begin
          state_reg  <= RD_ACK;
          rd_ack_reg <= 1'b1;
        end
        RD_ACK: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        WB_SETUP: begin
          // Register 0 is hardwired, so its strobe is suppressed.
          state_reg  <= WB_PULSE;
          rf_wre_reg <= (rf_rd_reg != '0);
        end
        WB_PULSE: begin
          state_reg  <= WB_HOLD;
          wb_ack_reg <= 1'b1;
        end
        WB_HOLD: begin
`ifdef REGACC_BYPASS_EN
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
`else
          if (rd_pend_reg) begin
            // The deferred read sees the value that was just written.
            rf_rs_reg   <= rs_cap_reg;
            rf_rt_reg   <= rt_cap_reg;
            rd_pend_reg <= 1'b0;
            state_reg   <= RD_ADDR;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
`endif
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign rd_ack   = rd_ack_reg;
  assign wb_ack   = wb_ack_reg;
  assign rf_wre   = rf_wre_reg;
  assign rf_rs    = rf_rs_reg;
  assign rf_rt    = rf_rt_reg;
  assign rf_rd    = rf_rd_reg;
  assign rf_wdata = rf_wdata_reg;
  assign a_out    = g_opnd[0].opnd_reg;
  assign b_out    = g_opnd[1].opnd_reg;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: scoreboard bench for reg_access_ctrl.
// Cycle label convention: label L is the clock cycle closed by rising edge L.
// A request driven during cycle L is therefore sampled at edge L (= N).
module tb_reg_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGACC_BYPASS_EN
  localparam int RD_BOTH_LAT = 2;
`else
  localparam int RD_BOTH_LAT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rs_in = '0;
  logic [AW-1:0] rt_in = '0;
  logic          rd_ack;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          wb_req = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_ack;
  logic          busy;
  logic [AW-1:0] rf_rs;
  logic [AW-1:0] rf_rt;
  logic [DW-1:0] rf_do1;
  logic [DW-1:0] rf_do2;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic          rf_wre;

  reg_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rs_in(rs_in), .rt_in(rt_in),
    .rd_ack(rd_ack), .a_out(a_out), .b_out(b_out),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .busy(busy),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_do1(rf_do1), .rf_do2(rf_do2),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_wre(rf_wre)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External register file: combinational reads, write on the rising edge.
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  assign rf_do1 = rf_mem[rf_rs];
  assign rf_do2 = rf_mem[rf_rt];
  always @(posedge clk) begin
    if (rf_wre && (rf_rd != '0)) rf_mem[rf_rd] <= rf_wdata;
  end

  // Reference model: architectural register contents plus expected events.
  typedef struct { int cyc; logic [DW-1:0] a; logic [DW-1:0] b; } rd_exp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wb_exp_t;
  logic [DW-1:0] model [32] = '{default: '0};
  rd_exp_t rd_q[$];
  wb_exp_t wb_q[$];
  wb_exp_t wre_q[$];
  bit busy_map[int];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
    check({tag, "_wb_ack"}, 64'(wb_ack), 64'd0);
    check({tag, "_rf_wre"}, 64'(rf_wre), 64'd0);
    check({tag, "_a_out"}, 64'(a_out), 64'd0);
    check({tag, "_b_out"}, 64'(b_out), 64'd0);
    check({tag, "_rf_rs"}, 64'(rf_rs), 64'd0);
    check({tag, "_rf_rt"}, 64'(rf_rt), 64'd0);
    check({tag, "_rf_rd"}, 64'(rf_rd), 64'd0);
    check({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
  endtask

  // Monitor: compares every DUT event against the scoreboard queues.
  logic [AW-1:0] prev_rf_rd = '0;
  logic [DW-1:0] prev_rf_wdata = '0;
  always @(negedge clk) begin
    int cur;
    rd_exp_t re;
    wb_exp_t we;
    cur = cyc + 1;
    if (rst_n) begin
      check("busy", 64'(busy), 64'(busy_map.exists(cur)));
      if (rd_ack) begin
        if (rd_q.size() == 0) begin
          check("rd_ack_unexpected", 64'(rd_ack), 64'd0);
        end else begin
          re = rd_q.pop_front();
          $display("txn rd_ack cycle %0d a=%h b=%h", cur, a_out, b_out);
          check("rd_ack_cycle", 64'(cur), 64'(re.cyc));
          check("a_out", 64'(a_out), 64'(re.a));
          check("b_out", 64'(b_out), 64'(re.b));
        end
      end
      if (wb_ack) begin
        if (wb_q.size() == 0) begin
          check("wb_ack_unexpected", 64'(wb_ack), 64'd0);
        end else begin
          we = wb_q.pop_front();
          $display("txn wb_ack cycle %0d addr=%0d data=%h", cur, rf_rd, rf_wdata);
          check("wb_ack_cycle", 64'(cur), 64'(we.cyc));
          check("hold_rf_rd", 64'(rf_rd), 64'(we.addr));
          check("hold_rf_wdata", 64'(rf_wdata), 64'(we.data));
          check("rf_committed", 64'(rf_mem[we.addr]), (we.addr == '0) ? 64'd0 : 64'(we.data));
        end
      end
      if (rf_wre) begin
        if (wre_q.size() == 0) begin
          check("rf_wre_unexpected", 64'(rf_wre), 64'd0);
        end else begin
          we = wre_q.pop_front();
          check("rf_wre_cycle", 64'(cur), 64'(we.cyc));
          check("pulse_rf_rd", 64'(rf_rd), 64'(we.addr));
          check("pulse_rf_wdata", 64'(rf_wdata), 64'(we.data));
          check("setup_rf_rd", 64'(prev_rf_rd), 64'(we.addr));
          check("setup_rf_wdata", 64'(prev_rf_wdata), 64'(we.data));
        end
      end
    end
    prev_rf_rd = rf_rd;
    prev_rf_wdata = rf_wdata;
  end

  // Issue a transaction (optionally repeated by holding the request) and
  // record what the model says must happen. Returns after the final ack cycle.
  task automatic issue(input bit do_wb, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit do_rd, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input int reps, input bit scramble);
    int n;
    int last;
    @(negedge clk); #2;
    wb_req = do_wb; wb_addr = wa; wb_data = wd;
    rd_req = do_rd; rs_in = rs; rt_in = rt;
    n = cyc + 1;
    last = n;
    for (int r = 0; r < reps; r++) begin
      last = n;
      if (do_wb) begin
        if (wa != '0) begin
          model[wa] = wd;
          wre_q.push_back('{n + 2, wa, wd});
        end
        wb_q.push_back('{n + 3, wa, wd});
        last = n + 3;
      end
      if (do_rd) begin
        int lat;
        lat = do_wb ? RD_BOTH_LAT : 2;
        rd_q.push_back('{n + lat, model[rs], model[rt]});
        if (n + lat > last) last = n + lat;
      end
      for (int k = n + 1; k <= last; k++) busy_map[k] = 1'b1;
      n = last + 1;
    end
    while (cyc + 1 < last) begin
      @(negedge clk); #2;
      if (scramble) begin
        wb_addr = AW'($urandom_range(0, 31));
        wb_data = $urandom;
        rs_in = AW'($urandom_range(0, 31));
        rt_in = AW'($urandom_range(0, 31));
      end
    end
    rd_req = 1'b0;
    wb_req = 1'b0;
  endtask

  // Watchdog: the run must always terminate.
  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    #1 rst_n = 1'b1;

    // Write r5 then read it back with r0.
    issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1, 1'b1);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1, 1'b1);
    // Write to r0 is acked but never strobed; r0 reads back as 0.
    issue(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 1, 1'b1);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1, 1'b1);
    // Simultaneous write and read with r3 preloaded to 1.
    issue(1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 5'd0, 1, 1'b1);
    issue(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd3, 1, 1'b1);
    // Held read request produces two transactions with an idle cycle between.
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd5, 2, 1'b0);

    // Reset in the middle of the write pulse: strobe drops, no ack follows.
    issue(1'b1, 5'd9, 32'h11112222, 1'b0, 5'd0, 5'd0, 1, 1'b1);
    @(negedge clk); #2;
    wb_req = 1'b1; wb_addr = 5'd9; wb_data = 32'hBAD0BAD0;
    n = cyc + 1;
    wre_q.push_back('{n + 2, 5'd9, 32'hBAD0BAD0});
    busy_map[n + 1] = 1'b1;
    busy_map[n + 2] = 1'b1;
    while (cyc + 1 < n + 2) begin
      @(negedge clk); #2;
    end
    rst_n = 1'b0;
    wb_req = 1'b0;
    #1 check_all_zero("midwrite_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd5, 1, 1'b1);

    // Randomized mix of reads, writes and simultaneous requests.
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      issue(kind != 0, AW'($urandom_range(0, 7)), $urandom,
            kind != 1, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1, 1'b1);
    end

    repeat (6) @(negedge clk);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wb_q_drained", 64'(wb_q.size()), 64'd0);
    check("wre_q_drained", 64'(wre_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Register-file access sequencer for the multicycle CPU: the initiator side of the register-file port. Accepts operand-read and write-back requests from the control FSM over a req/ack handshake, drives the register file's address, data and write-enable pins with safe setup/pulse/hold sequencing, and latches read operands into the A/B operand registers. It sits between the control unit and the register file, replacing direct control-unit drive of RegWre.

## Interface
- `DW`, 32, data width of operands and write data
- `AW`, 5, register address width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rd_req` in 1: operand-read request, level, held until `rd_ack`
- `rs_in`, `rt_in` in AW: source register addresses
- `rd_ack` out 1: one-cycle pulse; `a_out`/`b_out` valid from this cycle
- `a_out`, `b_out` out DW: latched operands, held until next read completes
- `wb_req` in 1: write-back request, level, held until `wb_ack`
- `wb_addr` in AW, `wb_data` in DW: write-back target and value
- `wb_ack` out 1: one-cycle pulse, write committed
- `busy` out 1: state != IDLE
- `rf_rs`, `rf_rt` out AW: to register-file read addresses
- `rf_do1`, `rf_do2` in DW: register-file combinational read data
- `rf_rd` out AW, `rf_wdata` out DW, `rf_wre` out 1: register-file write port

## Operation
- States: IDLE, RD_ADDR, RD_ACK, WB_SETUP, WB_PULSE, WB_HOLD.
- Requests sampled only in IDLE; `rs_in`/`rt_in`/`wb_addr`/`wb_data` captured into internal registers at the sampling edge; requester may change them afterwards.
- Read: IDLE -> RD_ADDR (drive `rf_rs`/`rf_rt`) -> RD_ACK (`a_out`/`b_out` loaded from `rf_do1`/`rf_do2` at RD_ADDR's closing edge, `rd_ack`=1) -> IDLE.
- Write: IDLE -> WB_SETUP (`rf_rd`/`rf_wdata` driven, `rf_wre`=0) -> WB_PULSE (`rf_wre`=1, exactly one cycle) -> WB_HOLD (`rf_wre`=0, addr/data still stable, `wb_ack`=1) -> IDLE. Address/data never change while `rf_wre`=1 or in the cycle before/after it.
- `wb_addr`=0: full sequence and `wb_ack` still occur, `rf_wre` never asserts.
- Both requests in IDLE (default build): write first; read marked pending; WB_HOLD -> RD_ADDR; read returns post-write values.
- A request held high after its ack is a new transaction, sampled in the following IDLE cycle.
- `rf_rs`/`rf_rt`/`rf_rd`/`rf_wdata` hold their last value when idle.

## Timing
- Reset (async assert): state IDLE, pending cleared; `a_out`, `b_out`, `rf_rs`, `rf_rt`, `rf_rd`, `rf_wdata` = 0; `rd_ack`, `wb_ack`, `rf_wre`, `busy` = 0. Mid-write reset drops `rf_wre` immediately; no ack issued.
- Read latency: `rd_req` sampled at edge N -> `rd_ack` high cycle N+2; `busy` high N+1..N+2.
- Write latency: `wb_req` sampled at edge N -> `rf_wre` high cycle N+2, `wb_ack` high cycle N+3.
- Simultaneous (default): `wb_ack` N+3, `rd_ack` N+5.
- Back-to-back: earliest next sample is the IDLE cycle after ack (read every 3 cycles, write every 4).

## Configuration
- `REGACC_BYPASS_EN` defined: simultaneous requests run in parallel; write sequence as normal, read path goes RD_ADDR/RD_ACK concurrently; any operand whose address equals nonzero `wb_addr` is taken from captured `wb_data` instead of `rf_do*`; `rd_ack` at N+2, `wb_ack` at N+3; return to IDLE after WB_HOLD.
- Undefined: serialized write-then-read as in Operation; no forwarding logic present.

## Test plan
- Reset: assert `rst_n`=0 mid-WB_PULSE -> `rf_wre` drops same cycle, all outputs 0, no ack after release.
- Write then read: wb r5=0xDEADBEEF -> `rf_wre` one cycle at N+2, `wb_ack` N+3; then read rs=5, rt=0 -> `rd_ack` at +2, `a_out`=0xDEADBEEF, `b_out`=0.
- Write r0=0x12345678 -> `wb_ack` at N+3, `rf_wre` never high, subsequent read of r0 returns 0.
- Simultaneous wb r7=0xA5A5A5A5 with read rs=7, rt=3 (r3=1) -> default: `wb_ack` N+3, `rd_ack` N+5, a=0xA5A5A5A5, b=1; with `REGACC_BYPASS_EN`: `rd_ack` N+2, same values.
- Held request: `rd_req` high 8 cycles -> `rd_ack` pulses at N+2 and N+5, `busy` low only in IDLE cycles.
- Input change after sampling: alter `wb_data` to 0 in cycle N+1 -> `rf_wdata` stays original through WB_HOLD, RF holds original value.
